// File: rtl/fetch_unit_pkg.sv
// Shared types and default parameters for the instruction fetch unit.
package fetch_unit_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'd0;
    localparam logic [31:0] DEFAULT_FINAL_PC = 32'd35;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_packet;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALT
    } fetch_state;

endpackage

// File: rtl/fetch_fifo.sv
// Purpose: 2-entry in-order buffer of fetch packets between memory return and decode.
// Latency: a push is visible at head the cycle after it is written; head is combinational.
// Backpressure: none internally; the owner keeps pushes within free space, flush wins over push/pop.
module fetch_fifo
    import fetch_unit_pkg::*;
(
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        push,
    input  fetch_packet push_dat,
    input  logic        pop,
    input  logic        flush,
    output logic        full,
    output logic        empty,
    output fetch_packet head
);

    fetch_packet mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic        push_ok;
    logic        pop_ok;

    // A push into a full buffer is only legal when the head leaves the same cycle.
    assign push_ok = push & (~full | pop);
    assign pop_ok  = pop & ~empty;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Purpose: sequential instruction fetch with redirect, stopping after FINAL_PC is consumed.
// Latency: first packet valid two edges after the first request; one packet per cycle steady state.
// Backpressure: INST_READY low stalls the head; requests stop once buffer plus in-flight reach 2.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] FINAL_PC = DEFAULT_FINAL_PC,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        CLK,
    input  logic        RSTN,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic [31:0] IMEM_RDATA,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    output logic        INST_VALID,
    input  logic        INST_READY,
    output logic [31:0] INSTRUCTION,
    output logic [31:0] INST_PC,
    output logic        HALTED
);

    fetch_state  state;
    fetch_state  state_nxt;
    logic [31:0] pc;
    logic        epoch;
    logic        infl_vld;
    logic        infl_epoch;
    logic [31:0] infl_pc;
    logic        resp_vld;
    logic        push;
    logic        pop;
    logic        issue;
    logic        fifo_full;
    logic        fifo_empty;
    logic [1:0]  buf_cnt;
    logic [1:0]  slots;
    fetch_packet head;
    fetch_packet push_dat;

    // Responses issued before a redirect carry the old epoch and are dropped.
    assign resp_vld = infl_vld & (infl_epoch == epoch);
    assign push     = resp_vld & ~REDIRECT;
    assign pop      = ~fifo_empty & INST_READY;
    assign buf_cnt  = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
    assign slots    = buf_cnt + {1'b0, resp_vld};
    assign push_dat = '{inst: IMEM_RDATA, pc: infl_pc};

    fetch_fifo u_fifo (
        .CLK      (CLK),
        .RSTN     (RSTN),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .flush    (REDIRECT),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (head)
    );

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // A head leaving this cycle frees its slot, which keeps delivery bubble-free.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            RUN: begin
                issue = ~REDIRECT & (pop ? (slots <= 2'd2) : (slots < 2'd2));
                if (issue && (pc == FINAL_PC)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && (head.pc == FINAL_PC)) begin
                    state_nxt = HALT;
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
        if (REDIRECT) begin
            state_nxt = RUN;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            pc         <= RESET_PC;
            epoch      <= 1'b0;
            infl_vld   <= 1'b0;
            infl_epoch <= 1'b0;
            infl_pc    <= 32'd0;
        end else begin
            infl_vld   <= issue;
            infl_epoch <= epoch;
            infl_pc    <= pc;
            if (REDIRECT) begin
                pc    <= REDIRECT_PC;
                epoch <= ~epoch;
            end else if (issue) begin
                pc <= pc + 32'd1;
            end
        end
    end

    // Request is gated by reset so nothing is presented to memory while held in reset.
    assign IMEM_REQ    = issue & RSTN;
    assign IMEM_ADDR   = pc;
    assign INST_VALID  = ~fifo_empty;
    assign INSTRUCTION = head.inst;
    assign INST_PC     = head.pc;
    assign HALTED      = (state == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stream, backpressure, redirect, halt, mid-stream reset, wrap.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'hDEADBEEF;
    logic        inst_valid;
    logic [31:0] instruction;
    logic [31:0] inst_pc;
    logic        halted;

    logic        w_ready = 1'b1;
    logic        w_redirect = 1'b0;
    logic [31:0] w_redirect_pc = 32'd0;
    logic        w_imem_req;
    logic [31:0] w_imem_addr;
    logic [31:0] w_imem_rdata = 32'hDEADBEEF;
    logic        w_inst_valid;
    logic [31:0] w_instruction;
    logic [31:0] w_inst_pc;
    logic        w_halted;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_pc = 32'd0;
    logic        hs = 1'b0;
    logic [31:0] hs_pc = 32'd0;
    logic [31:0] wrap_log [$];

    always #5 clk = ~clk;

    fetch_unit u_dut (
        .CLK         (clk),
        .RSTN        (rstn),
        .IMEM_REQ    (imem_req),
        .IMEM_ADDR   (imem_addr),
        .IMEM_RDATA  (imem_rdata),
        .REDIRECT    (redirect),
        .REDIRECT_PC (redirect_pc),
        .INST_VALID  (inst_valid),
        .INST_READY  (ready),
        .INSTRUCTION (instruction),
        .INST_PC     (inst_pc),
        .HALTED      (halted)
    );

    fetch_unit #(.FINAL_PC(32'd1), .RESET_PC(32'd0)) u_wrap (
        .CLK         (clk),
        .RSTN        (rstn),
        .IMEM_REQ    (w_imem_req),
        .IMEM_ADDR   (w_imem_addr),
        .IMEM_RDATA  (w_imem_rdata),
        .REDIRECT    (w_redirect),
        .REDIRECT_PC (w_redirect_pc),
        .INST_VALID  (w_inst_valid),
        .INST_READY  (w_ready),
        .INSTRUCTION (w_instruction),
        .INST_PC     (w_inst_pc),
        .HALTED      (w_halted)
    );

    // One-cycle memory: data for an accepted request appears after the next edge.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= imem_addr + 32'h100;
        if (w_imem_req) w_imem_rdata <= w_imem_addr + 32'h100;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; handshakes are sampled just before the rising edge.
    task automatic step();
        #2;
        hs    = inst_valid & ready;
        hs_pc = inst_pc;
        if (hs) begin
            check_eq("pkt_pc", inst_pc, exp_pc);
            check_eq("pkt_inst", instruction, exp_pc + 32'h100);
            exp_pc = exp_pc + 32'd1;
        end
        if (w_inst_valid & w_ready) begin
            wrap_log.push_back(w_inst_pc);
            check_eq("wrap_inst", w_instruction, w_inst_pc + 32'h100);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstn          = 1'b0;
        ready         = 1'b0;
        redirect      = 1'b0;
        redirect_pc   = 32'd0;
        w_redirect    = 1'b0;
        w_redirect_pc = 32'd0;
        #1;
        check_eq("rst_req", imem_req, 0);
        check_eq("rst_valid", inst_valid, 0);
        check_eq("rst_halted", halted, 0);
        check_eq("rst_inst", instruction, 0);
        check_eq("rst_pc", inst_pc, 0);
        @(negedge clk);
        @(negedge clk);
        rstn   = 1'b1;
        exp_pc = 32'd0;
        wrap_log.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        found;
        logic        early_halt;
        int          bad_req;
        int          late_req;
        logic [31:0] max_addr;
        logic [31:0] wexp [3];
        logic [31:0] wgot;

        #1;
        // Stream with decode always ready
        do_reset();
        ready = 1'b1;
        #1;
        check_eq("first_req", imem_req, 1);
        check_eq("first_addr", imem_addr, 0);
        check_eq("c1_valid", inst_valid, 0);
        step();
        #1;
        check_eq("c2_req", imem_req, 1);
        check_eq("c2_addr", imem_addr, 1);
        check_eq("c2_valid", inst_valid, 0);
        step();
        #1;
        check_eq("c3_valid", inst_valid, 1);
        step();
        repeat (8) step();
        check_eq("stream_count", exp_pc, 9);

        // Backpressure in cycles 3..6
        do_reset();
        ready = 1'b1;
        step();
        step();
        ready = 1'b0;
        #1;
        check_eq("bp_req_c3", imem_req, 0);
        step();
        for (int c = 4; c <= 6; c++) begin
            #1;
            check_eq("bp_req_hold", imem_req, 0);
            check_eq("bp_head_pc", inst_pc, 0);
            check_eq("bp_head_inst", instruction, 32'h100);
            step();
        end
        ready = 1'b1;
        #1;
        check_eq("bp_resume_req", imem_req, 1);
        check_eq("bp_resume_addr", imem_addr, 2);
        step();
        repeat (8) step();
        check_eq("bp_count", exp_pc, 9);

        // Redirect to 12 while 5 is returning and 4 is at the head
        do_reset();
        ready = 1'b1;
        repeat (6) step();
        redirect    = 1'b1;
        redirect_pc = 32'd12;
        #1;
        check_eq("rd_head", inst_pc, 4);
        check_eq("rd_no_req", imem_req, 0);
        step();
        redirect = 1'b0;
        check_eq("rd_consumed4", exp_pc, 5);
        exp_pc = 32'd12;
        #1;
        check_eq("rd_req", imem_req, 1);
        check_eq("rd_addr", imem_addr, 12);
        check_eq("rd_flushed", inst_valid, 0);
        step();
        #1;
        check_eq("rd_gap", inst_valid, 0);
        step();
        repeat (5) step();
        check_eq("rd_count", exp_pc, 17);

        // Free run to FINAL_PC, then halt and redirect out
        do_reset();
        ready      = 1'b1;
        found      = 1'b0;
        early_halt = 1'b0;
        bad_req    = 0;
        max_addr   = 32'd0;
        for (int i = 0; i < 100 && !found; i++) begin
            #1;
            if (imem_req && imem_addr > 32'd35) bad_req++;
            if (imem_req && imem_addr > max_addr) max_addr = imem_addr;
            if (halted) early_halt = 1'b1;
            step();
            if (hs && hs_pc == 32'd35) found = 1'b1;
        end
        check_eq("halt_seen35", found, 1);
        check_eq("halt_early", early_halt, 0);
        check_eq("halt_bad_req", bad_req, 0);
        check_eq("halt_last_addr", max_addr, 35);
        #1;
        check_eq("halt_rise", halted, 1);
        check_eq("halt_valid", inst_valid, 0);
        late_req = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (imem_req) late_req++;
            step();
        end
        check_eq("halt_no_req", late_req, 0);
        check_eq("halt_hold", halted, 1);
        redirect    = 1'b1;
        redirect_pc = 32'd4;
        #1;
        check_eq("halt_rd_no_req", imem_req, 0);
        step();
        redirect = 1'b0;
        exp_pc   = 32'd4;
        #1;
        check_eq("halt_cleared", halted, 0);
        check_eq("halt_rd_req", imem_req, 1);
        check_eq("halt_rd_addr", imem_addr, 4);
        repeat (5) step();
        check_eq("halt_rd_count", exp_pc, 7);

        // Reset pulse with two packets buffered
        do_reset();
        ready = 1'b1;
        step();
        step();
        ready = 1'b0;
        step();
        #1;
        check_eq("mr_pre_valid", inst_valid, 1);
        rstn = 1'b0;
        #1;
        check_eq("mr_valid", inst_valid, 0);
        check_eq("mr_req", imem_req, 0);
        check_eq("mr_pc", inst_pc, 0);
        step();
        rstn   = 1'b1;
        ready  = 1'b1;
        exp_pc = 32'd0;
        #1;
        check_eq("mr_req0", imem_req, 1);
        check_eq("mr_addr0", imem_addr, 0);
        check_eq("mr_c1_valid", inst_valid, 0);
        step();
        #1;
        check_eq("mr_c2_valid", inst_valid, 0);
        step();
        repeat (4) step();
        check_eq("mr_count", exp_pc, 4);

        // Wrap through 0xFFFFFFFF on the FINAL_PC=1 instance
        do_reset();
        ready = 1'b1;
        repeat (6) step();
        check_eq("wrap_pre_halt", w_halted, 1);
        wrap_log.delete();
        w_redirect    = 1'b1;
        w_redirect_pc = 32'hFFFF_FFFF;
        step();
        w_redirect = 1'b0;
        #1;
        check_eq("wrap_unhalt", w_halted, 0);
        check_eq("wrap_addr", w_imem_addr, 32'hFFFF_FFFF);
        repeat (8) step();
        check_eq("wrap_halted", w_halted, 1);
        check_eq("wrap_len", wrap_log.size(), 3);
        wexp[0] = 32'hFFFF_FFFF;
        wexp[1] = 32'd0;
        wexp[2] = 32'd1;
        for (int i = 0; i < 3; i++) begin
            wgot = (i < wrap_log.size()) ? wrap_log[i] : 32'hBAD0_BAD0;
            check_eq("wrap_pc", wgot, wexp[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
